// File: rtl/hdmi_line_fifo.sv
// ---------------------------------------------------------------------------
// hdmi_line_fifo
//   Single-clock pixel FIFO between the PLB master burst-read data path and
//   hdmi_core. Burst-read words are written in; hdmi_core pops one word per
//   active pixel and sees the head word combinationally (show-ahead).
//
// Ports:
//   Bus2IP_Clk     in   system clock, rising edge
//   Bus2IP_Resetn  in   synchronous reset, active low
//   flush          in   synchronous clear (frame start / read_done)
//   wr_en, wr_data in   write strobe and word from master read-data path
//   wr_ready       out  space available (registered ~full)
//   rd_en          in   pop strobe from hdmi_core
//   rd_data        out  head word, UNDERFLOW_COLOR while empty
//   empty/full     out  level == 0 / level == DEPTH (registered)
//   half_full      out  level >= HALF_FULL_LEVEL (registered)
//   level          out  current word count
//   overflow       out  sticky: write attempted while full
//   underflow      out  sticky: read attempted while empty
// ---------------------------------------------------------------------------
module hdmi_line_fifo #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 9,
    parameter int unsigned           HALF_FULL_LEVEL = 256,
    parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = '0
) (
    input  logic                  Bus2IP_Clk,
    input  logic                  Bus2IP_Resetn,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  half_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_HALF = (ADDR_WIDTH + 1)'(HALF_FULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q,  level_d;
    logic                  empty_q,  empty_d;
    logic                  full_q,   full_d;
    logic                  half_q,   half_d;
    logic                  ready_q,  ready_d;
    logic                  ovf_q,    ovf_d;
    logic                  unf_q,    unf_d;
    logic                  acc_wr,   acc_rd;

    // Acceptance uses the registered flags only, so a same-cycle read never
    // makes room for a write at full, and a same-cycle write never satisfies
    // a read at empty.
    always_comb begin
        acc_wr   = wr_en & ~full_q;
        acc_rd   = rd_en & ~empty_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (acc_wr) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (acc_rd) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        unique case ({acc_wr, acc_rd})
            2'b10:   level_d = level_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_WIDTH + 1)'(1);
            default: level_d = level_q;
        endcase

        ovf_d   = ovf_q | (wr_en & full_q);
        unf_d   = unf_q | (rd_en & empty_q);

        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_FULL);
        half_d  = (level_d >= LVL_HALF);
        ready_d = ~full_d;
    end

    // Reset and flush share one clear path; reset wins simply because either
    // one alone produces the same cleared state.
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            half_q   <= 1'b0;
            ready_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            half_q   <= half_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; a write coinciding with reset/flush is discarded.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Resetn && !flush && acc_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data   = empty_q ? UNDERFLOW_COLOR : mem[rd_ptr_q];
    assign wr_ready  = ready_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign half_full = half_q;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_hdmi_line_fifo.sv
module tb_hdmi_line_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned HALF  = 256;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          empty, full, half_full, overflow, underflow;
    logic [AW:0]   level;

    always #5 clk = ~clk;

    hdmi_line_fifo #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .HALF_FULL_LEVEL (HALF),
        .UNDERFLOW_COLOR (32'h00000000)
    ) dut (
        .Bus2IP_Clk    (clk),
        .Bus2IP_Resetn (rstn),
        .flush         (flush),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .empty         (empty),
        .full          (full),
        .half_full     (half_full),
        .level         (level),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    // Reference model: FIFO contents as a queue plus the two sticky flags.
    logic [DW-1:0] mdl_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            mon_en = 1'b0;
    int            tests = 0;
    int            fails = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // One clock cycle of stimulus. Inputs are applied just after a rising
    // edge; the model advances to its post-edge state just after the next one.
    task automatic step(input bit rst, input bit fl, input bit we,
                        input logic [DW-1:0] wd, input bit re);
        int unsigned sz;
        bit          aw, ar;
        rstn    = !rst;
        flush   = fl;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        sz = mdl_q.size();
        aw = we && (sz < DEPTH);
        ar = re && (sz > 0);
        if (!rst && !fl && ar) exp_q.push_back(mdl_q[0]);
        @(posedge clk);
        #1;
        if (rst || fl) begin
            mdl_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (we && sz == DEPTH) m_ovf = 1'b1;
            if (re && sz == 0)     m_unf = 1'b1;
            if (ar) void'(mdl_q.pop_front());
            if (aw) mdl_q.push_back(wd);
        end
    endtask

    // Monitor: status against the model every cycle; popped words against
    // the expected-response queue whenever the DUT performs a pop.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("level",     64'(level),     64'(mdl_q.size()));
            chk("empty",     64'(empty),     64'(mdl_q.size() == 0));
            chk("full",      64'(full),      64'(mdl_q.size() == DEPTH));
            chk("half_full", 64'(half_full), 64'(mdl_q.size() >= HALF));
            chk("wr_ready",  64'(wr_ready),  64'(mdl_q.size() < DEPTH));
            chk("overflow",  64'(overflow),  64'(m_ovf));
            chk("underflow", 64'(underflow), 64'(m_unf));
            if (mdl_q.size() == 0)
                chk("rd_data_empty", 64'(rd_data), 64'h0);
            if (rd_en && !empty && rstn && !flush) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pop: DUT popped %0h but no word expected", rd_data);
                end else begin
                    chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        // 1. reset held two cycles
        step(1, 0, 0, '0, 0);
        mon_en = 1'b1;
        step(1, 0, 0, '0, 0);

        // 2. fill to full, then one extra write
        for (int unsigned k = 0; k < DEPTH + 1; k++)
            step(0, 0, 1, 32'h80808000 + k * 32'h100, 0);
        step(0, 0, 0, '0, 0);

        // 3. drain completely
        for (int unsigned k = 0; k < DEPTH; k++)
            step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);

        // 4. hold level 5 with simultaneous push/pop
        for (int unsigned k = 0; k < 5; k++)
            step(0, 0, 1, 32'hA0000000 + k, 0);
        for (int unsigned k = 0; k < 10; k++)
            step(0, 0, 1, 32'hB0000000 + k, 1);
        for (int unsigned k = 0; k < 5; k++)
            step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);

        // 5. read on empty with write, then flush with write
        step(0, 0, 1, 32'hCAFE0001, 1);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 1);
        step(0, 1, 1, 32'hBAD0BAD0, 0);
        step(0, 0, 0, '0, 0);
        step(0, 0, 1, 32'h12345678, 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);

        // reset mid-burst discards everything
        for (int unsigned k = 0; k < 20; k++)
            step(0, 0, 1, 32'hD0000000 + k, 0);
        step(1, 0, 1, 32'hDEADDEAD, 1);
        step(0, 0, 1, 32'h55AA55AA, 0);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);

        // 6. random interleave, level kept within 1..511, wraps pointers
        step(0, 0, 1, $urandom, 0);
        for (int unsigned i = 0; i < 1500; i++) begin
            int unsigned sz;
            bit we, re;
            sz = mdl_q.size();
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            if (sz <= 1 && re && !we) re = 1'b0;
            if (sz >= DEPTH - 1 && we && !re) we = 1'b0;
            step(0, 0, we, $urandom, re);
        end
        step(0, 0, 0, '0, 0);
        chk("random_no_overflow",  64'(overflow),  64'h0);
        chk("random_no_underflow", 64'(underflow), 64'h0);

        @(negedge clk);
        #1;
        chk("expected_queue_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
